store_coalesce_buffer: RTL and testbench

Parametrised post-commit store buffer that sits between ROB store commit and the data cache. It holds committed stores in program order and merges same-word stores into one entry with byte-level write masks. It drains the oldest entry to the dcache over a valid/ready + response handshake, and forwards data byte-granularly to younger loads, reporting full hit, partial hit (load must stall) or miss.

---
 rtl/store_coalesce_buffer.sv | 163 ++++++++++++++++
 tb/tb_store_coalesce_buffer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/store_coalesce_buffer.sv
// Post-commit store queue: merges same-word stores under byte masks, drains the
// oldest entry to the dcache and forwards covered bytes to younger loads.
module store_coalesce_buffer #(
  parameter int DEPTH  = 8,
  parameter int IDX_W  = 3,
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_st_valid,
  output logic              o_st_ready,
  input  logic [ADDR_W-1:0] i_st_addr,
  input  logic [31:0]       i_st_wdata,
  input  logic [3:0]        i_st_wmask,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [3:0]        i_ld_rmask,
  output logic [31:0]       o_fwd_data,
  output logic              o_fwd_hit,
  output logic              o_fwd_partial,
  output logic              o_dmem_valid,
  input  logic              i_dmem_ready,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [31:0]       o_dmem_wdata,
  output logic [3:0]        o_dmem_wmask,
  input  logic              i_dmem_resp,
  output logic [IDX_W:0]    o_count,
  output logic              o_is_empty,
  output logic              o_is_full
);

  localparam int WA_W = ADDR_W - 2;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IDX_W:0]    r_head;
  logic [IDX_W:0]    r_tail;
  logic [IDX_W:0]    w_count;
  logic [WA_W-1:0]   r_waddr [DEPTH];
  logic [31:0]       r_data  [DEPTH];
  logic [3:0]        r_mask  [DEPTH];

  logic [IDX_W-1:0]  w_age_slot [DEPTH];
  logic [DEPTH-1:0]  w_age_live;
  logic [WA_W-1:0]   w_st_wa;
  logic [WA_W-1:0]   w_ld_wa;
  logic              w_st_found;
  logic [IDX_W-1:0]  w_st_slot;
  logic              w_mergeable;
  logic              w_st_fire;
  logic              w_alloc;
  logic              w_merge;
  logic              w_retire;
  logic [31:0]       w_st_bytes;
  logic [31:0]       w_fwd_raw;
  logic [3:0]        w_fwd_cov;
  logic [3:0]        w_cov;
  logic              w_unused_lsbs;

  assign w_st_wa       = i_st_addr[ADDR_W-1:2];
  assign w_ld_wa       = i_ld_addr[ADDR_W-1:2];
  assign w_unused_lsbs = ^{i_st_addr[1:0], i_ld_addr[1:0]};

  assign w_count    = r_tail - r_head;
  assign o_count    = w_count;
  assign o_is_empty = (w_count == '0);
  assign o_is_full  = (w_count == (IDX_W+1)'(DEPTH));

  // Age k maps to a physical slot; only ages below count lie inside the window.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    assign w_age_slot[g] = r_head[IDX_W-1:0] + IDX_W'(g);
    assign w_age_live[g] = ((IDX_W+1)'(g) < w_count);
  end

  always_comb begin
    w_st_found = 1'b0;
    w_st_slot  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_live[k] && (r_waddr[w_age_slot[k]] == w_st_wa)) begin
        w_st_found = 1'b1;
        w_st_slot  = w_age_slot[k];
      end
    end
  end

  // The head is frozen once the drain has started presenting it.
  assign w_mergeable = w_st_found &&
                       !((w_st_slot == r_head[IDX_W-1:0]) && (r_state != S_IDLE));
  assign o_st_ready  = w_mergeable || !o_is_full;
  assign w_st_fire   = i_st_valid && o_st_ready && (i_st_wmask != 4'b0000);
  assign w_alloc     = w_st_fire && !w_mergeable;
  assign w_merge     = w_st_fire && w_mergeable;
  assign w_retire    = (r_state == S_WAIT) && i_dmem_resp;
  assign w_st_bytes  = {{8{i_st_wmask[3]}}, {8{i_st_wmask[2]}},
                        {8{i_st_wmask[1]}}, {8{i_st_wmask[0]}}};

  always_comb begin
    w_fwd_raw = '0;
    w_fwd_cov = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_age_live[k] && (r_waddr[w_age_slot[k]] == w_ld_wa)) begin
        for (int b = 0; b < 4; b++) begin
          if (r_mask[w_age_slot[k]][b]) begin
            w_fwd_raw[8*b +: 8] = r_data[w_age_slot[k]][8*b +: 8];
            w_fwd_cov[b]        = 1'b1;
          end
        end
      end
    end
  end

  assign w_cov         = i_ld_rmask & w_fwd_cov;
  assign o_fwd_data    = w_fwd_raw & {{8{w_cov[3]}}, {8{w_cov[2]}},
                                      {8{w_cov[1]}}, {8{w_cov[0]}}};
  assign o_fwd_hit     = (i_ld_rmask != 4'b0000) && (w_cov == i_ld_rmask);
  assign o_fwd_partial = (w_cov != 4'b0000) && (w_cov != i_ld_rmask);

  assign o_dmem_addr  = {r_waddr[r_head[IDX_W-1:0]], 2'b00};
  assign o_dmem_wdata = r_data[r_head[IDX_W-1:0]];
  assign o_dmem_wmask = r_mask[r_head[IDX_W-1:0]];

  always_comb begin
    w_state_nxt  = r_state;
    o_dmem_valid = 1'b0;
    case (r_state)
      S_IDLE: if (!o_is_empty) w_state_nxt = S_REQ;
      S_REQ: begin
        o_dmem_valid = 1'b1;
        if (i_dmem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: if (i_dmem_resp) w_state_nxt = (w_count > (IDX_W+1)'(1)) ? S_REQ : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_head  <= '0;
      r_tail  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_alloc)  r_tail <= r_tail + (IDX_W+1)'(1);
      if (w_retire) r_head <= r_head + (IDX_W+1)'(1);
    end
  end

  // Entry payload is never reset; the pointer window alone decides liveness.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_alloc) begin
      r_waddr[r_tail[IDX_W-1:0]] <= w_st_wa;
      r_data[r_tail[IDX_W-1:0]]  <= i_st_wdata & w_st_bytes;
      r_mask[r_tail[IDX_W-1:0]]  <= i_st_wmask;
    end else if (i_rst && w_merge) begin
      for (int b = 0; b < 4; b++) begin
        if (i_st_wmask[b]) r_data[w_st_slot][8*b +: 8] <= i_st_wdata[8*b +: 8];
      end
      r_mask[w_st_slot] <= r_mask[w_st_slot] | i_st_wmask;
    end
  end

endmodule

// File: tb/tb_store_coalesce_buffer.sv
// Bench for store_coalesce_buffer: directed scenarios plus random traffic, all
// checked every cycle against a queue-based reference model of the buffer.
module tb_store_coalesce_buffer;

  localparam int DEPTH  = 8;
  localparam int IDX_W  = 3;
  localparam int ADDR_W = 32;
  localparam int M_IDLE = 0;
  localparam int M_REQ  = 1;
  localparam int M_WAIT = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              stValid;
  logic              stReady;
  logic [ADDR_W-1:0] stAddr;
  logic [31:0]       stWdata;
  logic [3:0]        stWmask;
  logic [ADDR_W-1:0] ldAddr;
  logic [3:0]        ldRmask;
  logic [31:0]       fwdData;
  logic              fwdHit;
  logic              fwdPartial;
  logic              dmemValid;
  logic              dmemReady;
  logic [ADDR_W-1:0] dmemAddr;
  logic [31:0]       dmemWdata;
  logic [3:0]        dmemWmask;
  logic              dmemResp;
  logic [IDX_W:0]    count;
  logic              isEmpty;
  logic              isFull;

  always #5 clk = ~clk;

  store_coalesce_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .ADDR_W(ADDR_W)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_st_valid(stValid), .o_st_ready(stReady), .i_st_addr(stAddr),
    .i_st_wdata(stWdata), .i_st_wmask(stWmask),
    .i_ld_addr(ldAddr), .i_ld_rmask(ldRmask),
    .o_fwd_data(fwdData), .o_fwd_hit(fwdHit), .o_fwd_partial(fwdPartial),
    .o_dmem_valid(dmemValid), .i_dmem_ready(dmemReady), .o_dmem_addr(dmemAddr),
    .o_dmem_wdata(dmemWdata), .o_dmem_wmask(dmemWmask), .i_dmem_resp(dmemResp),
    .o_count(count), .o_is_empty(isEmpty), .o_is_full(isFull)
  );

  typedef struct packed {
    logic [29:0] wa;
    logic [31:0] d;
    logic [3:0]  m;
  } ent_t;

  ent_t q[$];
  int   phase = M_IDLE;
  bit   modelValid = 1'b0;
  int   checks = 0;
  int   passes = 0;
  int   readyMode = 0;
  int   respMax = 1;
  int   respCnt = 0;
  bit   respHold = 1'b0;
  int   strayRate = 0;
  int   writes = 0;

  logic [IDX_W:0] capCount;
  logic           capEmpty, capFull, capReady, capHit, capPartial, capValid;
  logic [31:0]    capData, capAddr;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs === expv) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] laneMask(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  // One clock cycle: drive inputs, compare outputs with the model, then advance the model.
  task automatic applyStimulus(input bit doReset, input bit sv, input logic [31:0] sa,
                               input logic [31:0] sd, input logic [3:0] sm,
                               input logic [31:0] la, input logic [3:0] lm);
    logic [31:0] eFwd;
    logic [3:0]  cov;
    logic        eHit, ePart, eReady, found, mergeable, accept, dReady, dResp;
    int          idx, nPhase;
    ent_t        e;
    dReady = (readyMode == 1) || (readyMode == 2 && $urandom_range(0, 1) == 1);
    dResp  = 1'b0;
    if (phase == M_WAIT) begin
      if (respCnt == 0) dResp = !respHold;
      else respCnt--;
    end else if (strayRate == 1 || (strayRate == 2 && $urandom_range(0, 3) == 0)) begin
      dResp = 1'b1;
    end
    rst = !doReset; stValid = sv; stAddr = sa; stWdata = sd; stWmask = sm;
    ldAddr = la; ldRmask = lm; dmemReady = dReady; dmemResp = dResp;
    #1;
    cov = 4'b0000; eFwd = 32'h0;
    foreach (q[i]) begin
      if (q[i].wa == la[31:2]) begin
        for (int b = 0; b < 4; b++) begin
          if (q[i].m[b]) begin
            eFwd[8*b +: 8] = q[i].d[8*b +: 8];
            cov[b] = 1'b1;
          end
        end
      end
    end
    cov   = cov & lm;
    eFwd  = eFwd & laneMask(cov);
    eHit  = (lm != 4'b0000) && (cov == lm);
    ePart = (cov != 4'b0000) && (cov != lm);
    found = 1'b0; idx = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (!found && q[i].wa == sa[31:2]) begin
        found = 1'b1;
        idx = i;
      end
    end
    mergeable = found && !(idx == 0 && phase != M_IDLE);
    eReady    = mergeable || (q.size() < DEPTH);
    capCount = count; capEmpty = isEmpty; capFull = isFull; capReady = stReady;
    capHit = fwdHit; capPartial = fwdPartial; capData = fwdData;
    capValid = dmemValid; capAddr = dmemAddr;
    if (modelValid) begin
      checkOutput("count", 64'(count), 64'(q.size()));
      checkOutput("is_empty", 64'(isEmpty), 64'(q.size() == 0));
      checkOutput("is_full", 64'(isFull), 64'(q.size() == DEPTH));
      checkOutput("st_ready", 64'(stReady), 64'(eReady));
      checkOutput("fwd_data", 64'(fwdData), 64'(eFwd));
      checkOutput("fwd_hit", 64'(fwdHit), 64'(eHit));
      checkOutput("fwd_partial", 64'(fwdPartial), 64'(ePart));
      checkOutput("dmem_valid", 64'(dmemValid), 64'(phase == M_REQ));
      if (phase == M_REQ) begin
        checkOutput("dmem_addr", 64'(dmemAddr), 64'({q[0].wa, 2'b00}));
        checkOutput("dmem_wmask", 64'(dmemWmask), 64'(q[0].m));
        checkOutput("dmem_wdata", 64'(dmemWdata & laneMask(q[0].m)), 64'(q[0].d));
      end
    end
    accept = sv && eReady && (sm != 4'b0000);
    if (doReset) begin
      q.delete();
      phase = M_IDLE;
      modelValid = 1'b1;
    end else if (modelValid) begin
      nPhase = phase;
      case (phase)
        M_IDLE: if (q.size() != 0) nPhase = M_REQ;
        M_REQ: if (dReady) begin
          nPhase = M_WAIT;
          writes++;
          respCnt = $urandom_range(0, respMax);
        end
        default: if (dResp) nPhase = (q.size() > 1) ? M_REQ : M_IDLE;
      endcase
      if (accept && mergeable) begin
        e = q[idx];
        e.d = (e.d & ~laneMask(sm)) | (sd & laneMask(sm));
        e.m = e.m | sm;
        q[idx] = e;
      end else if (accept) begin
        e.wa = sa[31:2]; e.d = sd & laneMask(sm); e.m = sm;
        q.push_back(e);
      end
      if (phase == M_WAIT && dResp) void'(q.pop_front());
      phase = nPhase;
    end
    @(posedge clk); #1;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic storeCycle(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    applyStimulus(1'b0, 1'b1, a, d, m, 32'h0, 4'h0);
  endtask

  task automatic loadCycle(input logic [31:0] a, input logic [3:0] m);
    applyStimulus(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, a, m);
  endtask

  task automatic resetCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic waitDrained(input int budget);
    int n = 0;
    while (!(q.size() == 0 && phase == M_IDLE) && n < budget) begin
      idleCycle();
      n++;
    end
    checkOutput("drain_timeout", 64'(n < budget), 64'(1));
  endtask

  initial begin
    bit sawReq;
    int n;
    resetCycle();
    resetCycle();
    idleCycle();
    checkOutput("reset_count", 64'(capCount), 64'(0));
    checkOutput("reset_empty", 64'(capEmpty), 64'(1));
    checkOutput("reset_ready", 64'(capReady), 64'(1));

    readyMode = 0;
    storeCycle(32'h100, 32'hAABBCCDD, 4'b1111);
    idleCycle();
    checkOutput("sw_count", 64'(capCount), 64'(1));
    readyMode = 1; respMax = 2; sawReq = 1'b0;
    for (int i = 0; i < 20 && !(q.size() == 0 && phase == M_IDLE); i++) begin
      idleCycle();
      if (capValid && capAddr == 32'h100) sawReq = 1'b1;
    end
    checkOutput("first_req_seen", 64'(sawReq), 64'(1));
    idleCycle();
    checkOutput("first_drained", 64'(capEmpty), 64'(1));

    resetCycle();
    readyMode = 0;
    storeCycle(32'h200, 32'h00000011, 4'b0001);
    idleCycle();
    idleCycle();
    storeCycle(32'h202, 32'h00220000, 4'b0100);
    storeCycle(32'h300, 32'h00003344, 4'b0011);
    checkOutput("frozen_head_alloc", 64'(capCount), 64'(2));
    storeCycle(32'h301, 32'h00550000, 4'b0100);
    idleCycle();
    checkOutput("merge_count", 64'(capCount), 64'(3));
    loadCycle(32'h300, 4'b0011);
    checkOutput("ld300_hit", 64'(capHit), 64'(1));
    checkOutput("ld300_data", 64'(capData), 64'(32'h00003344));
    loadCycle(32'h300, 4'b1111);
    checkOutput("ld300_partial", 64'(capPartial), 64'(1));
    checkOutput("ld300_pdata", 64'(capData), 64'(32'h00553344));
    loadCycle(32'h400, 4'b1111);
    checkOutput("ld400_flags", 64'({capHit, capPartial}), 64'(0));
    loadCycle(32'h200, 4'b0101);
    checkOutput("ld200_hit", 64'(capHit), 64'(1));
    checkOutput("ld200_data", 64'(capData), 64'(32'h00220011));
    readyMode = 1;
    waitDrained(60);

    resetCycle();
    readyMode = 0;
    for (int i = 0; i < DEPTH; i++) storeCycle(32'h1000 + 32'(4 * i), $urandom, 4'b1111);
    idleCycle();
    checkOutput("fill_full", 64'(capFull), 64'(1));
    applyStimulus(1'b0, 1'b1, 32'h2000, 32'h12345678, 4'b1111, 32'h0, 4'h0);
    checkOutput("full_new_word", 64'(capReady), 64'(0));
    storeCycle(32'h100C, 32'h000000EE, 4'b0001);
    checkOutput("full_merge_ok", 64'(capReady), 64'(1));
    storeCycle(32'h1000, 32'h000000EE, 4'b0001);
    checkOutput("full_head_word", 64'(capReady), 64'(0));
    readyMode = 2; respMax = 3; writes = 0;
    waitDrained(400);
    checkOutput("drain_writes", 64'(writes), 64'(DEPTH));
    idleCycle();
    checkOutput("drain_empty", 64'(capEmpty), 64'(1));

    resetCycle();
    readyMode = 1; respHold = 1'b1;
    storeCycle(32'h500, 32'h01020304, 4'b1111);
    storeCycle(32'h504, 32'h05060708, 4'b1111);
    storeCycle(32'h508, 32'h090A0B0C, 4'b1111);
    n = 0;
    while (phase != M_WAIT && n < 20) begin
      idleCycle();
      n++;
    end
    checkOutput("reach_wait", 64'(phase == M_WAIT), 64'(1));
    resetCycle();
    idleCycle();
    checkOutput("rst_wait_count", 64'(capCount), 64'(0));
    checkOutput("rst_wait_valid", 64'(capValid), 64'(0));
    respHold = 1'b0; strayRate = 1;
    repeat (4) idleCycle();
    strayRate = 0;
    idleCycle();
    checkOutput("stray_ignored", 64'(capCount), 64'(0));

    resetCycle();
    readyMode = 2; respMax = 3; strayRate = 2;
    for (int i = 0; i < 800; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(0, 1)),
                    32'h100 + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)),
                    32'h100 + 32'($urandom_range(0, 11) * 4), 4'($urandom_range(0, 15)));
    end
    strayRate = 0;
    waitDrained(400);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
